// File: rtl/weight_buf_pingpong.sv
// Ping-pong weight buffer: a loader fills the shadow bank element by element while readers fetch full kernel rows from the active bank.
// Read latency 1 cycle, or 2 with WEIGHT_BUF_OUTREG_EN defined. Loader backpressure: wr_ready is high only while a fill is in progress.
module weight_buf_pingpong #(
    parameter int DATA_WIDTH   = 8,
    parameter int IN_CHANNELS  = 3,
    parameter int OUT_CHANNELS = 4,
    parameter int KERNEL_SIZE  = 1,
    localparam int ROW_ELEMS   = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int ROW_W       = DATA_WIDTH * ROW_ELEMS,
    localparam int AW          = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
    localparam int LW          = (ROW_ELEMS > 1) ? $clog2(ROW_ELEMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  load_done,
    output logic                  shadow_full,
    input  logic                  swap,
    output logic                  active_bank,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [ROW_W-1:0]      rd_data,
    output logic                  rd_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   row_cnt_q;
    logic [LW-1:0]   lane_cnt_q;
    logic            active_bank_q;
    logic            load_done_q;
    logic            wr_fire;
    logic            last_elem;
    logic            swap_fire;
    logic            addr_ok;

    logic [ROW_W-1:0] mem [2][OUT_CHANNELS];

    // A restart pulse owns its cycle: any element offered alongside it is dropped.
    assign wr_fire   = wr_valid && (state_q == LOAD) && !load_start;
    assign last_elem = (row_cnt_q == AW'(OUT_CHANNELS - 1)) && (lane_cnt_q == LW'(ROW_ELEMS - 1));
    assign swap_fire = swap && (state_q == FULL);

    assign wr_ready    = (state_q == LOAD);
    assign shadow_full = (state_q == FULL);
    assign active_bank = active_bank_q;
    assign load_done   = load_done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = IDLE;
            LOAD: if (wr_fire && last_elem) state_d = FULL;
            FULL: if (swap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Swap in FULL still toggles the bank this edge, so the new fill lands in the freshly retired bank.
        if (load_start) state_d = LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            lane_cnt_q    <= '0;
            active_bank_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= wr_fire && last_elem;
            if (swap_fire) active_bank_q <= ~active_bank_q;
            if (load_start) begin
                row_cnt_q  <= '0;
                lane_cnt_q <= '0;
            end else if (wr_fire) begin
                if (lane_cnt_q == LW'(ROW_ELEMS - 1)) begin
                    lane_cnt_q <= '0;
                    row_cnt_q  <= last_elem ? '0 : row_cnt_q + 1'b1;
                end else begin
                    lane_cnt_q <= lane_cnt_q + 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left unreset; only the shadow bank is ever written.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int j = 0; j < ROW_ELEMS; j++) begin
                if (lane_cnt_q == LW'(j))
                    mem[~active_bank_q][row_cnt_q][j*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
            end
        end
    end

    generate
        if ((1 << AW) > OUT_CHANNELS) begin : g_addr_chk
            assign addr_ok = ({1'b0, rd_addr} < (AW+1)'(OUT_CHANNELS));
        end else begin : g_addr_full
            assign addr_ok = 1'b1;
        end
    endgenerate

    logic [ROW_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // Bank select uses the pre-edge active_bank, so a read coinciding with a swap sees the old bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_data_q  <= (rd_en && addr_ok) ? mem[active_bank_q][rd_addr] : '0;
        end
    end

`ifdef WEIGHT_BUF_OUTREG_EN
    logic [ROW_W-1:0] rd_data_q2;
    logic             rd_valid_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q2 <= 1'b0;
            rd_data_q2  <= '0;
        end else begin
            rd_valid_q2 <= rd_valid_q;
            rd_data_q2  <= rd_data_q;
        end
    end

    assign rd_data  = rd_data_q2;
    assign rd_valid = rd_valid_q2;
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_weight_buf_pingpong.sv
// Directed bench for weight_buf_pingpong: default geometry plus a 3x3 kernel instance.
module tb_weight_buf_pingpong;

`ifdef WEIGHT_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, wr_valid, swap, rd_en;
    logic [7:0]  wr_data;
    logic [1:0]  rd_addr;
    logic        wr_ready, load_done, shadow_full, active_bank, rd_valid;
    logic [23:0] rd_data;

    logic        k3_load_start, k3_wr_valid, k3_swap, k3_rd_en;
    logic [7:0]  k3_wr_data;
    logic [1:0]  k3_rd_addr;
    logic        k3_wr_ready, k3_load_done, k3_shadow_full, k3_active_bank, k3_rd_valid;
    logic [143:0] k3_rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_buf_pingpong dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done),
        .shadow_full(shadow_full), .swap(swap), .active_bank(active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    weight_buf_pingpong #(.IN_CHANNELS(2), .KERNEL_SIZE(3)) dut_k3 (
        .clk(clk), .rst_n(rst_n), .load_start(k3_load_start), .wr_valid(k3_wr_valid),
        .wr_data(k3_wr_data), .wr_ready(k3_wr_ready), .load_done(k3_load_done),
        .shadow_full(k3_shadow_full), .swap(k3_swap), .active_bank(k3_active_bank),
        .rd_en(k3_rd_en), .rd_addr(k3_rd_addr), .rd_data(k3_rd_data), .rd_valid(k3_rd_valid)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_row(input logic [1:0] addr, input logic [23:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        if (LAT == 2) tick();
        chk({tag, "_data"}, rd_data, exp);
        chk({tag, "_vld"}, rd_valid, 1'b1);
    endtask

    task automatic stream12(input int base);
        for (int n = 0; n < 12; n++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(base + n);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int pulses;
        logic exp_acc;
        logic [143:0] k3_exp;

        rst_n = 1'b0;
        load_start = 0; wr_valid = 0; wr_data = 0; swap = 0; rd_en = 0; rd_addr = 0;
        k3_load_start = 0; k3_wr_valid = 0; k3_wr_data = 0; k3_swap = 0; k3_rd_en = 0; k3_rd_addr = 0;
        tick();
        tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_shadow_full", shadow_full, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_active_bank", active_bank, 0);
        rst_n = 1'b1;
        tick();

        // Basic fill of bank 1, swap, read all rows.
        load_start = 1; tick(); load_start = 0;
        chk("load_wr_ready", wr_ready, 1);
        for (int n = 0; n < 12; n++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(10 * (n / 3 + 1) + n % 3);
            tick();
        end
        wr_valid = 0;
        chk("fill_load_done", load_done, 1);
        chk("fill_shadow_full", shadow_full, 1);
        chk("fill_wr_ready", wr_ready, 0);
        tick();
        chk("fill_done_once", load_done, 0);
        swap = 1; tick(); swap = 0;
        chk("swap_bank", active_bank, 1);
        chk("swap_not_full", shadow_full, 0);
        read_row(2'd0, 24'h0C0B0A, "row0");
        read_row(2'd1, 24'h161514, "row1");
        read_row(2'd2, 24'h201F1E, "row2");
        read_row(2'd3, 24'h2A2928, "row3");
        tick();
        if (LAT == 2) tick();
        chk("idle_rd_data", rd_data, 0);
        chk("idle_rd_valid", rd_valid, 0);

        // Shadow fill (+100) under continuous reads of row 2.
        rd_en = 1; rd_addr = 2;
        load_start = 1; tick(); load_start = 0;
        for (int n = 0; n < 12; n++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(110 + 10 * (n / 3) + n % 3);
            tick();
            chk("concur_rd", rd_data, 24'h201F1E);
        end
        wr_valid = 0;
        tick();
        swap = 1; tick(); swap = 0;
        chk("swap_cycle_rd", rd_data, 24'h201F1E);
        tick();
        chk("post_swap_rd1", rd_data, (LAT == 1) ? 24'h848382 : 24'h201F1E);
        tick();
        chk("post_swap_rd2", rd_data, 24'h848382);
        rd_en = 0;
        chk("swap2_bank", active_bank, 0);

        // wr_valid every other cycle into bank 1.
        load_start = 1; tick(); load_start = 0;
        acc = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            wr_valid = (i % 2 == 0);
            wr_data  = 8'(50 + acc);
            exp_acc  = wr_valid && (acc < 12);
            tick();
            if (exp_acc) acc++;
            if (load_done) pulses++;
            if (exp_acc && acc == 12) chk("toggle_done_timing", load_done, 1);
        end
        wr_valid = 0;
        chk("toggle_pulses", pulses, 1);
        chk("toggle_wr_ready", wr_ready, 0);
        chk("toggle_full", shadow_full, 1);
        swap = 1; tick(); swap = 0;
        read_row(2'd0, 24'h343332, "toggle_row0");

        // Abort after 5 elements, swap while loading ignored, restart with 1..12 into bank 0.
        pulses = 0;
        load_start = 1; tick(); load_start = 0;
        for (int n = 0; n < 5; n++) begin
            wr_valid = 1; wr_data = 8'(200 + n); tick();
            if (load_done) pulses++;
        end
        wr_valid = 0;
        swap = 1; tick(); swap = 0;
        chk("swap_in_load_ignored", active_bank, 1);
        load_start = 1; tick(); load_start = 0;
        for (int n = 0; n < 12; n++) begin
            if (n == 11) chk("restart_no_early_done", pulses, 0);
            wr_valid = 1; wr_data = 8'(n + 1); tick();
            if (load_done) pulses++;
        end
        wr_valid = 0;
        chk("restart_done", pulses, 1);
        swap = 1; tick(); swap = 0;
        chk("restart_bank", active_bank, 0);
        read_row(2'd1, 24'h060504, "restart_row1");
        read_row(2'd0, 24'h030201, "restart_row0");
        swap = 1; tick(); swap = 0;
        chk("swap_in_idle_ignored", active_bank, 0);

        // load_start in FULL discards; then swap + load_start together.
        load_start = 1; tick(); load_start = 0;
        stream12(0);
        chk("full_again", shadow_full, 1);
        load_start = 1; tick(); load_start = 0;
        chk("discard_not_full", shadow_full, 0);
        chk("discard_wr_ready", wr_ready, 1);
        stream12(0);
        swap = 1; load_start = 1; tick(); swap = 0; load_start = 0;
        chk("swapstart_bank", active_bank, 1);
        chk("swapstart_wr_ready", wr_ready, 1);
        chk("swapstart_not_full", shadow_full, 0);

        // Asynchronous reset mid-load with a read in flight.
        for (int n = 0; n < 3; n++) begin
            wr_valid = 1; wr_data = 8'(n); tick();
        end
        wr_valid = 0;
        rd_en = 1; rd_addr = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_bank", active_bank, 0);
        chk("arst_wr_ready", wr_ready, 0);
        chk("arst_full", shadow_full, 0);
        chk("arst_done", load_done, 0);
        rd_en = 0;
        tick();
        rst_n = 1;
        tick(); tick();
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_rd_data", rd_data, 0);
        chk("post_rst_no_load", wr_ready, 0);

        // 3x3 kernel, 2 input channels: 18 lanes per row.
        k3_load_start = 1; tick(); k3_load_start = 0;
        for (int n = 1; n <= 72; n++) begin
            k3_wr_valid = 1; k3_wr_data = 8'(n); tick();
        end
        k3_wr_valid = 0;
        chk("k3_done", k3_load_done, 1);
        k3_swap = 1; tick(); k3_swap = 0;
        k3_rd_en = 1; k3_rd_addr = 2'd3; tick(); k3_rd_en = 0;
        if (LAT == 2) tick();
        for (int j = 0; j < 18; j++) k3_exp[j*8 +: 8] = 8'(55 + j);
        chk("k3_row3", k3_rd_data, k3_exp);
        chk("k3_row3_vld", k3_rd_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
